// File: rtl/regfile_wr_queue.sv
// In-order write queue in front of the 32x32 register file, with read-address snooping/forwarding.
// Optional macro REGFILE_WR_BYPASS_EN: forward the write being accepted this cycle as well.
module regfile_wr_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         In_Valid,
  output logic                         In_Ready,
  input  logic [AW-1:0]                In_Addr,
  input  logic [DW-1:0]                In_Data,
  input  logic                         Hold,
  output logic [AW-1:0]                Awr,
  output logic [DW-1:0]                Din,
  output logic                         WrEn,
  input  logic [AW-1:0]                Ard1,
  input  logic [AW-1:0]                Ard2,
  output logic                         Fwd1_Hit,
  output logic [DW-1:0]                Fwd1_Data,
  output logic                         Fwd2_Hit,
  output logic [DW-1:0]                Fwd2_Data,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign Count    = count;
  assign Empty    = (count == '0);
  // Gated by Reset_n so the producer sees no ready while reset is held.
  assign In_Ready = Reset_n && (count < CW'(DEPTH));
  assign WrEn     = !Empty && !Hold;
  assign pop      = WrEn;
  // Writes to register 0 complete the handshake but are dropped.
  assign push     = In_Valid && In_Ready && (In_Addr != '0);
  assign Awr      = Empty ? '0 : q_addr[rd_ptr];
  assign Din      = Empty ? '0 : q_data[rd_ptr];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (push) begin
        q_addr[wr_ptr] <= In_Addr;
        q_data[wr_ptr] <= In_Data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk from oldest to youngest so the last match (youngest) wins.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
    logic [DW:0]   r;
    logic [PW-1:0] idx;
    r = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (q_addr[idx] == a)) begin
        r = {1'b1, q_data[idx]};
      end
    end
`ifdef REGFILE_WR_BYPASS_EN
    if (push && (In_Addr == a)) begin
      r = {1'b1, In_Data};
    end
`else
`endif
    if (a == '0) begin
      r = '0;
    end
    return r;
  endfunction

  assign {Fwd1_Hit, Fwd1_Data} = lookup(Ard1);
  assign {Fwd2_Hit, Fwd2_Data} = lookup(Ard2);

endmodule
